// File: rtl/doodle_pkg.sv
// rtl/doodle_pkg.sv - shared platform types, screen geometry and LFSR constants
package doodle_pkg;

  localparam int          SCREEN_H  = 480;
  localparam int          SPACING   = 30;
  localparam int          X_MAX     = 72;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef struct packed {
    logic [6:0] x;
    logic [8:0] y;
  } plat_t;

  typedef enum logic [1:0] {INIT, IDLE, UPDATE, DONE} upd_state_t;

  // Folds the 0..127 LFSR column back into 0..X_MAX.
  function automatic logic [6:0] spawn_x(input logic [15:0] lfsr);
    if (lfsr[6:0] <= 7'(X_MAX)) return lfsr[6:0];
    else return lfsr[6:0] - 7'd64;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit right-shifting Galois LFSR, steps only when adv is high
module lfsr16
  import doodle_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        adv,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (adv) value_d = (value_q >> 1) ^ (value_q[0] ? LFSR_MASK : 16'h0000);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) value_q <= seed;
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/platform_updater.sv
// rtl/platform_updater.sv - seeds and scrolls the platform bank, one registered write per cycle
module platform_updater
  import doodle_pkg::*;
#(
  parameter int N_PLAT = 16
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          restart,
  input  logic                          frame_start,
  input  logic [4:0]                    scroll,
  input  logic [N_PLAT-1:0][15:0]       plat_q,
  output logic                          Load,
  output logic [$clog2(N_PLAT)-1:0]     index,
  output logic [15:0]                   D,
  output logic                          busy,
  output logic                          done,
  output logic                          overrun
);

  localparam int IW = $clog2(N_PLAT);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] CNT_END = CW'(N_PLAT);

  upd_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    scroll_q, scroll_d;
  logic          load_q, load_d;
  logic [IW-1:0] index_q, index_d;
  logic [15:0]   d_q, d_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          overrun_q, overrun_d;
  logic          lfsr_adv;
  logic [15:0]   lfsr_val;

  logic [IW-1:0] sel_idx;
  logic [4:0]    sel_scroll;
  plat_t         cur, upd_entry, init_entry;
  logic [9:0]    ny;
  logic          wrap;

  lfsr16 u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .adv   (lfsr_adv),
    .seed  (LFSR_SEED),
    .value (lfsr_val)
  );

  // Entry 0 is emitted straight from IDLE so its write lands one cycle after frame_start.
  assign sel_idx    = (state_q == IDLE) ? '0 : cnt_q[IW-1:0];
  assign sel_scroll = (state_q == IDLE) ? scroll : scroll_q;
  assign cur        = plat_q[sel_idx];
  assign ny         = {1'b0, cur.y} + {5'd0, sel_scroll};
  assign wrap       = (ny >= 10'(SCREEN_H));
  assign upd_entry  = wrap ? {spawn_x(lfsr_val), 9'(ny - 10'(SCREEN_H))} : {cur.x, ny[8:0]};
  assign init_entry = {spawn_x(lfsr_val), 9'(32'(cnt_q) * SPACING)};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    scroll_d  = scroll_q;
    load_d    = 1'b0;
    index_d   = index_q;
    d_d       = d_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    lfsr_adv  = 1'b0;
    if (restart) begin
      state_d   = INIT;
      cnt_d     = '0;
      overrun_d = 1'b0;
    end else begin
      if (frame_start && state_q != IDLE) overrun_d = 1'b1;
      case (state_q)
        INIT: begin
          if (cnt_q != CNT_END) begin
            load_d   = 1'b1;
            index_d  = sel_idx;
            d_d      = init_entry;
            lfsr_adv = 1'b1;
            cnt_d    = cnt_q + 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
        IDLE: begin
          if (frame_start) begin
            scroll_d = scroll;
            if (scroll == 5'd0) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              load_d   = 1'b1;
              index_d  = sel_idx;
              d_d      = upd_entry;
              lfsr_adv = wrap;
              cnt_d    = CW'(1);
              state_d  = UPDATE;
            end
          end
        end
        UPDATE: begin
          if (cnt_q != CNT_END) begin
            load_d   = 1'b1;
            index_d  = sel_idx;
            d_d      = upd_entry;
            lfsr_adv = wrap;
            cnt_d    = cnt_q + 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == INIT) || (state_d == UPDATE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= INIT;
      cnt_q     <= '0;
      scroll_q  <= '0;
      load_q    <= 1'b0;
      index_q   <= '0;
      d_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      scroll_q  <= scroll_d;
      load_q    <= load_d;
      index_q   <= index_d;
      d_q       <= d_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign Load    = load_q;
  assign index   = index_q;
  assign D       = d_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_platform_updater.sv
// tb/tb_platform_updater.sv - randomized self-checking bench with a bank model and frame-level reference
module tb_platform_updater;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              restart, frame_start;
  logic [4:0]        scroll;
  logic [15:0][15:0] plat_q;
  logic              Load;
  logic [3:0]        index;
  logic [15:0]       D;
  logic              busy, done, overrun;

  logic [15:0] bank [16];
  logic        poke_en;
  logic [3:0]  poke_idx;
  logic [15:0] poke_val;

  logic [15:0] exp_bank [16];
  logic [15:0] exp_w [16];
  logic [15:0] m_lfsr;

  logic        cap_load [64];
  logic [3:0]  cap_idx  [64];
  logic [15:0] cap_d    [64];
  logic        cap_done [64];
  logic        cap_busy [64];
  logic        cap_ovr  [64];

  int n_tests = 0;
  int n_fail  = 0;

  platform_updater #(.N_PLAT(16)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .restart     (restart),
    .frame_start (frame_start),
    .scroll      (scroll),
    .plat_q      (plat_q),
    .Load        (Load),
    .index       (index),
    .D           (D),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (poke_en)   bank[poke_idx] <= poke_val;
    else if (Load) bank[index]    <= D;
  end

  always_comb begin
    for (int i = 0; i < 16; i++) plat_q[i] = bank[i];
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [6:0] px(input logic [15:0] v);
    logic [6:0] l;
    l = v[6:0];
    return (l <= 7'd72) ? l : l - 7'd64;
  endfunction

  task automatic model_init();
    for (int i = 0; i < 16; i++) begin
      exp_w[i]    = {px(m_lfsr), 9'(i * 30)};
      exp_bank[i] = exp_w[i];
      m_lfsr      = lfsr_step(m_lfsr);
    end
  endtask

  // Only the first nw writes reach the bank (a pass cut short by restart/reset).
  task automatic model_update(input int s, input int nw);
    int y;
    for (int i = 0; i < 16; i++) begin
      y = int'(exp_bank[i][8:0]) + s;
      if (y >= 480) begin
        exp_w[i] = {px(m_lfsr), 9'(y - 480)};
        if (i < nw) m_lfsr = lfsr_step(m_lfsr);
      end else begin
        exp_w[i] = {exp_bank[i][15:9], 9'(y)};
      end
      if (i < nw) exp_bank[i] = exp_w[i];
    end
  endtask

  task automatic capture(input int n, input int fs_at, input int rs_at);
    for (int c = 0; c < n; c++) begin
      cap_load[c] = Load;
      cap_idx[c]  = index;
      cap_d[c]    = D;
      cap_done[c] = done;
      cap_busy[c] = busy;
      cap_ovr[c]  = overrun;
      frame_start = (c == fs_at);
      restart     = (c == rs_at);
      @(negedge Clk);
    end
    frame_start = 1'b0;
    restart     = 1'b0;
  endtask

  task automatic pulse_frame(input int s);
    scroll      = 5'(s);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({Load, index, D, busy, done, overrun} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got Load=%b index=%0d D=%h busy=%b done=%b overrun=%b, want all 0",
               Load, index, D, busy, done, overrun);
    end
  endtask

  // Called with reset just released at a falling edge; checks the whole INIT pass.
  task automatic test_init_pass(input string tag);
    @(negedge Clk);
    capture(18, -1, -1);
    m_lfsr = 16'hACE1;
    model_init();
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if ({cap_load[i], cap_idx[i], cap_d[i]} !== {1'b1, 4'(i), exp_w[i]}) begin
        n_fail++;
        $display("FAIL %s_write%0d: got Load=%b idx=%0d D=%h, want Load=1 idx=%0d D=%h",
                 tag, i, cap_load[i], cap_idx[i], cap_d[i], i, exp_w[i]);
      end
    end
    n_tests++;
    if ({cap_busy[0], cap_done[15], cap_done[16], cap_load[16], cap_busy[16], cap_ovr[17]} !== 6'b101000) begin
      n_fail++;
      $display("FAIL %s_done_busy: got busy0=%b done15=%b done16=%b load16=%b busy16=%b ovr=%b, want 101000",
               tag, cap_busy[0], cap_done[15], cap_done[16], cap_load[16], cap_busy[16], cap_ovr[17]);
    end
  endtask

  task automatic test_scroll_no_wrap();
    pulse_frame(5);
    capture(18, -1, -1);
    model_update(5, 16);
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if ({cap_load[i], cap_idx[i], cap_d[i]} !== {1'b1, 4'(i), exp_w[i]} || cap_d[i][8:0] !== 9'(i * 30 + 5)) begin
        n_fail++;
        $display("FAIL scroll5_write%0d: got Load=%b idx=%0d D=%h, want idx=%0d D=%h",
                 i, cap_load[i], cap_idx[i], cap_d[i], i, exp_w[i]);
      end
    end
    n_tests++;
    if (cap_done[16] !== 1'b1) begin
      n_fail++;
      $display("FAIL scroll5_done: got %b want 1", cap_done[16]);
    end
  endtask

  task automatic test_wrap_spawn();
    poke_idx = 4'd3;
    poke_val = {7'd10, 9'd478};
    poke_en  = 1'b1;
    @(negedge Clk);
    poke_en     = 1'b0;
    exp_bank[3] = {7'd10, 9'd478};
    pulse_frame(4);
    capture(18, -1, -1);
    model_update(4, 16);
    n_tests++;
    if (cap_idx[3] !== 4'd3 || cap_d[3][8:0] !== 9'd2 || cap_d[3][15:9] > 7'd72) begin
      n_fail++;
      $display("FAIL wrap_idx3: got idx=%0d y=%0d x=%0d, want idx=3 y=2 x<=72", cap_idx[3], cap_d[3][8:0], cap_d[3][15:9]);
    end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if ({cap_load[i], cap_idx[i], cap_d[i]} !== {1'b1, 4'(i), exp_w[i]}) begin
        n_fail++;
        $display("FAIL wrap_write%0d: got D=%h want %h", i, cap_d[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_overrun();
    int s;
    s = $urandom_range(1, 31);
    pulse_frame(s);
    capture(18, 7, -1);
    model_update(s, 16);
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if ({cap_load[i], cap_idx[i], cap_d[i]} !== {1'b1, 4'(i), exp_w[i]}) begin
        n_fail++;
        $display("FAIL overrun_write%0d: got D=%h want %h", i, cap_d[i], exp_w[i]);
      end
    end
    n_tests++;
    if ({cap_ovr[7], cap_ovr[8], cap_ovr[17], cap_done[16]} !== 4'b0111) begin
      n_fail++;
      $display("FAIL overrun_flag: got ovr7=%b ovr8=%b ovr17=%b done16=%b, want 0111",
               cap_ovr[7], cap_ovr[8], cap_ovr[17], cap_done[16]);
    end
  endtask

  task automatic test_restart_midpass();
    int s;
    s = $urandom_range(1, 31);
    pulse_frame(s);
    capture(27, -1, 7);
    model_update(s, 8);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if ({cap_load[i], cap_idx[i], cap_d[i]} !== {1'b1, 4'(i), exp_w[i]}) begin
        n_fail++;
        $display("FAIL restart_upd_write%0d: got D=%h want %h", i, cap_d[i], exp_w[i]);
      end
    end
    n_tests++;
    if ({cap_ovr[6], cap_load[8], cap_ovr[8]} !== 3'b100) begin
      n_fail++;
      $display("FAIL restart_cut: got ovr6=%b load8=%b ovr8=%b, want 100", cap_ovr[6], cap_load[8], cap_ovr[8]);
    end
    model_init_from_current();
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if ({cap_load[9+i], cap_idx[9+i], cap_d[9+i]} !== {1'b1, 4'(i), exp_w[i]}) begin
        n_fail++;
        $display("FAIL restart_init_write%0d: got idx=%0d D=%h want D=%h", i, cap_idx[9+i], cap_d[9+i], exp_w[i]);
      end
    end
    n_tests++;
    if (cap_done[25] !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_done: got %b want 1", cap_done[25]);
    end
  endtask

  // INIT after restart continues from the current LFSR value rather than the seed.
  task automatic model_init_from_current();
    model_init();
  endtask

  task automatic test_restart_priority();
    capture(20, 0, 0);
    model_init();
    n_tests++;
    if ({cap_load[1], cap_ovr[1], cap_ovr[19], cap_done[18]} !== 4'b0001) begin
      n_fail++;
      $display("FAIL prio_flags: got load1=%b ovr1=%b ovr19=%b done18=%b, want 0001",
               cap_load[1], cap_ovr[1], cap_ovr[19], cap_done[18]);
    end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if ({cap_load[2+i], cap_idx[2+i], cap_d[2+i]} !== {1'b1, 4'(i), exp_w[i]}) begin
        n_fail++;
        $display("FAIL prio_init_write%0d: got D=%h want %h", i, cap_d[2+i], exp_w[i]);
      end
    end
  endtask

  task automatic test_skip_zero();
    pulse_frame(0);
    capture(4, -1, -1);
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if ({cap_load[c], cap_done[c]} !== {1'b0, c == 0}) begin
        n_fail++;
        $display("FAIL skip_cycle%0d: got Load=%b done=%b, want Load=0 done=%b", c, cap_load[c], cap_done[c], c == 0);
      end
    end
  endtask

  task automatic test_random_frames();
    int s;
    for (int f = 0; f < 14; f++) begin
      s = $urandom_range(1, 31);
      pulse_frame(s);
      capture(18, -1, -1);
      model_update(s, 16);
      for (int i = 0; i < 16; i++) begin
        n_tests++;
        if ({cap_load[i], cap_idx[i], cap_d[i]} !== {1'b1, 4'(i), exp_w[i]}) begin
          n_fail++;
          $display("FAIL rand_f%0d_s%0d_write%0d: got idx=%0d D=%h want D=%h", f, s, i, cap_idx[i], cap_d[i], exp_w[i]);
        end
      end
      n_tests++;
      if ({cap_done[16], cap_load[16], cap_busy[17]} !== 3'b100) begin
        n_fail++;
        $display("FAIL rand_f%0d_done: got done=%b load=%b busy=%b, want 100", f, cap_done[16], cap_load[16], cap_busy[17]);
      end
    end
  endtask

  task automatic test_reset_midpass();
    int s;
    s = $urandom_range(1, 31);
    pulse_frame(s);
    capture(4, -1, -1);
    Reset = 1'b0;
    #1;
    n_tests++;
    if ({Load, index, D, busy, done, overrun} !== 24'd0) begin
      n_fail++;
      $display("FAIL midpass_reset: got Load=%b index=%0d D=%h busy=%b, want all 0", Load, index, D, busy);
    end
    @(negedge Clk);
    Reset = 1'b1;
    test_init_pass("reinit");
  endtask

  initial begin
    Reset       = 1'b0;
    restart     = 1'b0;
    frame_start = 1'b0;
    scroll      = 5'd0;
    poke_en     = 1'b0;
    poke_idx    = 4'd0;
    poke_val    = 16'd0;
    repeat (3) @(negedge Clk);
    test_reset();
    Reset = 1'b1;
    test_init_pass("init");
    test_scroll_no_wrap();
    test_wrap_spawn();
    test_overrun();
    test_restart_midpass();
    test_restart_priority();
    test_skip_zero();
    test_random_frames();
    test_reset_midpass();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
